// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, command bytes, LED bit positions
// and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_IDLE
  } tx_state_t;

  // Host commands and device responses
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;

  // Argument bits of CMD_SET_LED
  localparam int LED_SCROLL = 0;
  localparam int LED_NUM    = 1;
  localparam int LED_CAPS   = 2;

  // Falling edge that presents the parity bit; the next one releases data (stop).
  localparam logic [3:0] PARITY_EDGE = 4'd9;
  localparam logic [3:0] STOP_EDGE   = 4'd10;

  // Odd parity: data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Pad synchronizer plus falling-edge qualifier for the PS/2 clock.
// An edge counts only after the clock has stayed low for three samples,
// so 1- and 2-cycle glitches never produce a fall.
module ps2_clk_filter
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic fall,
  output logic clk_level,
  output logic dat
);

  logic [1:0] clk_sync_reg;
  logic [1:0] dat_sync_reg;
  logic [3:0] hist_reg;

  // Two-flop synchronizers (idle high) and the clock sample history, newest in bit 3
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_reg <= 2'b11;
      dat_sync_reg <= 2'b11;
      hist_reg     <= 4'b0000;
    end else begin
      clk_sync_reg <= {clk_sync_reg[0], ps2_clk};
      dat_sync_reg <= {dat_sync_reg[0], ps2_dat};
      hist_reg     <= {clk_sync_reg[1], hist_reg[3:1]};
    end
  end

  assign fall      = (hist_reg == 4'b0001);
  assign clk_level = clk_sync_reg[1];
  assign dat       = dat_sync_reg[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends start, 8 data
// bits LSB first, odd parity and stop, then checks the device ACK bit.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ   = 48000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int CYC_PER_US     = CLK_FREQ / 1000000;
  localparam int INHIBIT_CYCLES = CYC_PER_US * INHIBIT_US;
  localparam int TIMEOUT_CYCLES = CYC_PER_US * TIMEOUT_US;
  localparam int CNT_MAX        = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W          = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INHIBIT_HALF = CNT_W'(INHIBIT_CYCLES / 2);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  tx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;        // inhibit length, then SEND/ACK timeout
  logic [3:0]       bit_cnt_reg;    // qualified falling edges seen in SEND
  logic [8:0]       shift_reg;      // {parity, data}, shifted out LSB first
  logic             line_reg;       // data level currently presented in SEND
  logic             err_flag_reg;   // ACK bit was high
  logic             idle_prev_reg;  // both lines were high last cycle
  logic             done_reg;
  logic             error_reg;

  logic fall;
  logic clk_level;
  logic dat_level;
  logic timeout;
  logic idle_ok;

  ps2_clk_filter u_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .fall      (fall),
    .clk_level (clk_level),
    .dat       (dat_level)
  );

  assign timeout = ((state_reg == SEND) || (state_reg == ACK)) && (cnt_reg == TIMEOUT_LAST);
  assign idle_ok = idle_prev_reg && clk_level && dat_level;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; the timeout overrides any edge seen in the same cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (tx_valid) state_next = INHIBIT;
      INHIBIT:   if (cnt_reg == INHIBIT_LAST) state_next = SEND;
      SEND: begin
        if (timeout) state_next = IDLE;
        else if (fall && (bit_cnt_reg == PARITY_EDGE)) state_next = ACK;
      end
      ACK: begin
        if (timeout) state_next = IDLE;
        else if (fall) state_next = WAIT_IDLE;
      end
      WAIT_IDLE: if (idle_ok) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Datapath: frame shifting, counters and the done/error pulses.
  // A missing ACK is remembered and reported when the bus goes idle, so the
  // error pulse lines up with busy falling just like done does.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg       <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      line_reg      <= 1'b1;
      err_flag_reg  <= 1'b0;
      idle_prev_reg <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
      idle_prev_reg <= clk_level && dat_level;
      case (state_reg)
        IDLE: begin
          if (tx_valid) begin
            shift_reg    <= {odd_parity(tx_data), tx_data};
            bit_cnt_reg  <= '0;
            cnt_reg      <= '0;
            err_flag_reg <= 1'b0;
            line_reg     <= 1'b0;  // start bit
          end
        end
        INHIBIT: begin
          cnt_reg <= (cnt_reg == INHIBIT_LAST) ? '0 : cnt_reg + CNT_W'(1);
        end
        SEND, ACK: begin
          if (timeout) begin
            error_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (fall) begin
              if (state_reg == SEND) begin
                if (bit_cnt_reg != STOP_EDGE) bit_cnt_reg <= bit_cnt_reg + 4'd1;
                if (bit_cnt_reg == PARITY_EDGE) begin
                  line_reg <= 1'b1;  // stop bit: release data
                end else begin
                  line_reg  <= shift_reg[0];
                  shift_reg <= {1'b0, shift_reg[8:1]};
                end
              end else if (dat_level) begin
                err_flag_reg <= 1'b1;
              end
            end
          end
        end
        WAIT_IDLE: begin
          if (idle_ok) begin
            if (err_flag_reg) error_reg <= 1'b1;
            else              done_reg  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: open-drain enables and handshake flags
  always_comb begin
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    case (state_reg)
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = (cnt_reg >= INHIBIT_HALF);
      end
      SEND:    ps2_dat_oe = ~line_reg;
      default: ;
    endcase
    tx_ready = (state_reg == IDLE);
    busy     = (state_reg != IDLE);
    done     = done_reg;
    error    = error_reg;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model that
// clocks the bus, samples the host's bits and drives the ACK bit.
module tb_ps2_host_tx;

  localparam int INH = 40;    // inhibit cycles at 1 MHz / 40 us
  localparam int TMO = 3000;  // timeout cycles at 1 MHz / 3000 us
  localparam int HP  = 20;    // device clock half period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk, ps2_dat;
  logic       ps2_clk_oe, ps2_dat_oe, tx_ready, busy, done, error;

  // Open-drain bus: either side pulls low
  assign ps2_clk = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.CLK_FREQ(1000000), .INHIBIT_US(40), .TIMEOUT_US(3000)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Pulse / transfer monitors
  int   done_cnt = 0, err_cnt = 0, busy_bad = 0, both_cnt = 0, oe_rise = 0;
  logic clk_oe_d = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (error === 1'b1) err_cnt <= err_cnt + 1;
    if ((done === 1'b1 || error === 1'b1) && busy !== 1'b0) busy_bad <= busy_bad + 1;
    if (done === 1'b1 && error === 1'b1) both_cnt <= both_cnt + 1;
    if (ps2_clk_oe === 1'b1 && clk_oe_d === 1'b0) oe_rise <= oe_rise + 1;
    clk_oe_d <= ps2_clk_oe;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Request a byte and measure how long the clock line is inhibited.
  // Returns on the first cycle after the clock is released.
  task automatic start_tx(input logic [7:0] d, input bit hold, output int inh_len);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    if (hold) tx_data = 8'h00;  // must not affect the latched byte
    else      tx_valid = 1'b0;
    inh_len = 0;
    while (ps2_clk_oe === 1'b1 && inh_len < INH + 50) begin
      inh_len++;
      @(negedge clk);
    end
  endtask

  // Device model: n_edges clock pulses, sampling the data line at the end
  // of each low phase; with 10 edges it then clocks the ACK bit.
  task automatic dev_run(input int n_edges, input bit ack_low, input bit glitch,
                         output logic [10:0] frame, output logic par_oe, output logic busy_all);
    int g;
    frame    = '0;
    frame[0] = ps2_dat;
    busy_all = busy;
    par_oe   = 1'b0;
    cyc(2 * HP);
    for (int i = 1; i <= n_edges; i++) begin
      dev_clk_low = 1'b1;
      cyc(HP);
      frame[i] = ps2_dat;
      busy_all = busy_all & busy;
      if (i == 9) par_oe = ps2_dat_oe;
      dev_clk_low = 1'b0;
      if (glitch && (i == 3 || i == 5)) begin
        g = (i == 3) ? 1 : 2;
        cyc(5);
        dev_clk_low = 1'b1;
        cyc(g);
        dev_clk_low = 1'b0;
        cyc(HP - 5 - g);
      end else begin
        cyc(HP);
      end
    end
    if (n_edges >= 10) begin
      dev_dat_low = ack_low;
      dev_clk_low = 1'b1;
      cyc(HP);
      busy_all = busy_all & busy;
      dev_clk_low = 1'b0;
      cyc(2);
      dev_dat_low = 1'b0;
    end
  endtask

  // Wait (bounded) for done or error, drop tx_valid in that same cycle.
  task automatic wait_pulse();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1 || error === 1'b1) seen = 1'b1;
    end
    tx_valid = 1'b0;
    cyc(10);
  endtask

  initial begin
    int          inh, n, d0, e0, r0;
    logic [10:0] frame;
    logic        par_oe, busy_all;

    // Reset state
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);

    // 0xED with device ACK
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED, 1'b0, inh);
    check("ed_inhibit_len", 32'(inh), 32'(INH));
    check("ed_start_oe", 32'(ps2_dat_oe), 32'd1);
    dev_run(10, 1'b1, 1'b0, frame, par_oe, busy_all);
    wait_pulse();
    check("ed_frame", 32'(frame), 32'b11111011010);
    check("ed_done", 32'(done_cnt - d0), 32'd1);
    check("ed_error", 32'(err_cnt - e0), 32'd0);
    check("ed_busy_span", 32'(busy_all), 32'd1);
    check("ed_ready_after", 32'(tx_ready), 32'd1);
    $display("tx 0xED frame=%b inhibit=%0d", frame, inh);

    // 0x02: parity bit 0
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h02, 1'b0, inh);
    check("x02_inhibit_len", 32'(inh), 32'(INH));
    dev_run(10, 1'b1, 1'b0, frame, par_oe, busy_all);
    wait_pulse();
    check("x02_parity_oe", 32'(par_oe), 32'd1);
    check("x02_frame", 32'(frame), 32'b10000000100);
    check("x02_done", 32'(done_cnt - d0), 32'd1);
    $display("tx 0x02 frame=%b inhibit=%0d", frame, inh);

    // 0xFF with ACK bit left high
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hFF, 1'b0, inh);
    dev_run(10, 1'b0, 1'b0, frame, par_oe, busy_all);
    wait_pulse();
    check("noack_error", 32'(err_cnt - e0), 32'd1);
    check("noack_done", 32'(done_cnt - d0), 32'd0);
    check("noack_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("noack_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("noack_ready", 32'(tx_ready), 32'd1);
    $display("tx 0xFF frame=%b no ack", frame);

    // Device never clocks: timeout
    d0 = done_cnt;
    start_tx(8'hF4, 1'b0, inh);
    n = 0;
    while (error !== 1'b1 && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", 32'(n), 32'(TMO));
    check("tmo_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("tmo_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);
    cyc(10);
    check("tmo_no_done", 32'(done_cnt - d0), 32'd0);
    $display("tx 0xF4 timeout after %0d cycles", n);

    // Reset in the middle of SEND
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h00, 1'b0, inh);
    dev_run(4, 1'b1, 1'b0, frame, par_oe, busy_all);
    check("mid_dat_oe_before", 32'(ps2_dat_oe), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("mid_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("mid_ready", 32'(tx_ready), 32'd1);
    reset = 1'b0;
    cyc(20);
    check("mid_no_done", 32'(done_cnt - d0), 32'd0);
    check("mid_no_error", 32'(err_cnt - e0), 32'd0);
    $display("tx 0x00 reset after 4 edges");

    // 0xF4 with clock glitches and tx_valid held through the transfer
    d0 = done_cnt; e0 = err_cnt; r0 = oe_rise;
    start_tx(8'hF4, 1'b1, inh);
    dev_run(10, 1'b1, 1'b1, frame, par_oe, busy_all);
    wait_pulse();
    cyc(100);
    check("f4_frame", 32'(frame), 32'b10111101000);
    check("f4_done", 32'(done_cnt - d0), 32'd1);
    check("f4_error", 32'(err_cnt - e0), 32'd0);
    check("f4_one_transfer", 32'(oe_rise - r0), 32'd1);
    check("f4_idle_busy", 32'(busy), 32'd0);
    $display("tx 0xF4 frame=%b glitched, valid held", frame);

    check("pulse_busy_low", 32'(busy_bad), 32'd0);
    check("pulse_exclusive", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
